// File: rtl/omp_col_sched.sv
// Column scheduler: clears the OMP RAMs, starts the core, drains RAM_S per column.
// Optional RUN watchdog is built only when OMP_SCHED_TIMEOUT_EN is defined.
module omp_col_sched #(
    parameter int COL_NUM     = 64,
    parameter int COL_W       = 6,
    parameter int Q_MEM_SIZE  = 256,
    parameter int R_MEM_SIZE  = 36,
    parameter int S_MEM_SIZE  = 256,
    parameter int CLR_DEPTH   = 256,
    parameter int AW          = 8,
    parameter int DW          = 16,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             batch_start,
    output logic             batch_busy,
    output logic             batch_done,
    output logic [COL_W-1:0] col_idx,
    output logic             mem_sel,
    output logic             omp_start,
    input  logic             omp_done,
    output logic [AW-1:0]    clr_a,
    output logic             clr_q_we,
    output logic             clr_r_we,
    output logic             clr_inv_r_we,
    output logic             clr_s_we,
    output logic [AW-1:0]    s_a,
    output logic             s_oe,
    input  logic [DW-1:0]    s_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_last,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_START, S_RUN, S_DRAIN, S_NEXT
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_idx_q, col_idx_d;
    logic               busy_q, busy_d;
    logic               bdone_q, bdone_d;
    logic               mem_sel_q, mem_sel_d;
    logic               omp_start_q, omp_start_d;
    logic [AW-1:0]      clr_a_q, clr_a_d;
    logic [3:0]         clr_we_q, clr_we_d;
    logic [AW-1:0]      s_a_q, s_a_d;
    logic               s_oe_q, s_oe_d;
    logic [AW:0]        rd_cnt_q, rd_cnt_d;
    logic               rd_v_q, rd_v_d;
    logic               rd_last_q, rd_last_d;
    logic               omp_done_q, omp_done_d;
    logic [DW-1:0]      fifo_data_q [2];
    logic [DW-1:0]      fifo_data_d [2];
    logic [1:0]         fifo_last_q, fifo_last_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         cnt_q, cnt_d;

    logic               head_v, xfer, fifo_pop, fifo_push, room, done_edge;
    logic [AW:0]        clr_nxt;

`ifdef OMP_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]      run_cnt_q, run_cnt_d;
    logic               tmo_q, tmo_d;
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    // bits: [3] S, [2] INV_R, [1] R, [0] Q
    function automatic logic [3:0] clr_we_f(input logic [AW:0] a);
        clr_we_f = {a < (AW+1)'(S_MEM_SIZE), a < (AW+1)'(R_MEM_SIZE),
                    a < (AW+1)'(R_MEM_SIZE), a < (AW+1)'(Q_MEM_SIZE)};
    endfunction

    assign batch_busy   = busy_q;
    assign batch_done   = bdone_q;
    assign col_idx      = col_idx_q;
    assign mem_sel      = mem_sel_q;
    assign omp_start    = omp_start_q;
    assign clr_a        = clr_a_q;
    assign clr_q_we     = clr_we_q[0];
    assign clr_r_we     = clr_we_q[1];
    assign clr_inv_r_we = clr_we_q[2];
    assign clr_s_we     = clr_we_q[3];
    assign s_a          = s_a_q;
    assign s_oe         = s_oe_q;

    // Read data landing on s_q is presented directly when the FIFO is empty,
    // and parked in the FIFO if it is not taken that cycle.
    always_comb begin
        head_v      = (cnt_q != 2'd0);
        out_valid   = head_v | rd_v_q;
        out_data    = head_v ? fifo_data_q[rd_ptr_q] : (rd_v_q ? s_q : '0);
        out_last    = head_v ? fifo_last_q[rd_ptr_q] : (rd_v_q & rd_last_q);
        xfer        = out_valid & out_ready;
        fifo_pop    = xfer & head_v;
        fifo_push   = rd_v_q & (head_v | ~out_ready);
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (fifo_push) begin
            fifo_data_d[wr_ptr_q] = s_q;
            fifo_last_d[wr_ptr_q] = rd_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (fifo_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d      = cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
        room       = ({1'b0, cnt_d} + {2'b0, s_oe_q}) < 3'd2;
        rd_v_d     = s_oe_q;
        rd_last_d  = s_oe_q && (s_a_q == AW'(S_MEM_SIZE - 1));
        omp_done_d = omp_done;
        done_edge  = omp_done & ~omp_done_q;
        clr_nxt    = {1'b0, clr_a_q} + (AW+1)'(1);
    end

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        busy_d      = busy_q;
        bdone_d     = 1'b0;
        mem_sel_d   = mem_sel_q;
        omp_start_d = 1'b0;
        clr_a_d     = clr_a_q;
        clr_we_d    = 4'b0;
        s_a_d       = s_a_q;
        s_oe_d      = 1'b0;
        rd_cnt_d    = rd_cnt_q;
`ifdef OMP_SCHED_TIMEOUT_EN
        run_cnt_d   = run_cnt_q;
        tmo_d       = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (batch_start) begin
                    state_d   = S_CLEAR;
                    col_idx_d = '0;
                    busy_d    = 1'b1;
                    mem_sel_d = 1'b1;
                    clr_a_d   = '0;
                    clr_we_d  = clr_we_f('0);
                end
            end
            S_CLEAR: begin
                if (clr_a_q == AW'(CLR_DEPTH - 1)) begin
                    state_d     = S_START;
                    mem_sel_d   = 1'b0;
                    omp_start_d = 1'b1;
                    clr_a_d     = '0;
                end else begin
                    clr_a_d  = clr_nxt[AW-1:0];
                    clr_we_d = clr_we_f(clr_nxt);
                end
            end
            S_START: begin
                state_d = S_RUN;
`ifdef OMP_SCHED_TIMEOUT_EN
                run_cnt_d = '0;
`endif
            end
            S_RUN: begin
                if (done_edge) begin
                    state_d   = S_DRAIN;
                    mem_sel_d = 1'b1;
                    s_oe_d    = 1'b1;
                    s_a_d     = '0;
                    rd_cnt_d  = (AW+1)'(1);
                end
`ifdef OMP_SCHED_TIMEOUT_EN
                else if (run_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d   = S_NEXT;
                    mem_sel_d = 1'b1;
                    tmo_d     = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + TW'(1);
                end
`endif
            end
            S_DRAIN: begin
                if (rd_cnt_q < (AW+1)'(S_MEM_SIZE) && room) begin
                    s_oe_d   = 1'b1;
                    s_a_d    = rd_cnt_q[AW-1:0];
                    rd_cnt_d = rd_cnt_q + (AW+1)'(1);
                end
                if (xfer && out_last) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (col_idx_q == COL_W'(COL_NUM - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    bdone_d = 1'b1;
                end else begin
                    state_d   = S_CLEAR;
                    col_idx_d = col_idx_q + COL_W'(1);
                    clr_a_d   = '0;
                    clr_we_d  = clr_we_f('0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            col_idx_q   <= '0;
            busy_q      <= 1'b0;
            bdone_q     <= 1'b0;
            mem_sel_q   <= 1'b1;
            omp_start_q <= 1'b0;
            clr_a_q     <= '0;
            clr_we_q    <= 4'b0;
            s_a_q       <= '0;
            s_oe_q      <= 1'b0;
            rd_cnt_q    <= '0;
            rd_v_q      <= 1'b0;
            rd_last_q   <= 1'b0;
            omp_done_q  <= 1'b0;
            for (int i = 0; i < 2; i++) fifo_data_q[i] <= '0;
            fifo_last_q <= 2'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
`ifdef OMP_SCHED_TIMEOUT_EN
            run_cnt_q   <= '0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            busy_q      <= busy_d;
            bdone_q     <= bdone_d;
            mem_sel_q   <= mem_sel_d;
            omp_start_q <= omp_start_d;
            clr_a_q     <= clr_a_d;
            clr_we_q    <= clr_we_d;
            s_a_q       <= s_a_d;
            s_oe_q      <= s_oe_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_v_q      <= rd_v_d;
            rd_last_q   <= rd_last_d;
            omp_done_q  <= omp_done_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
`ifdef OMP_SCHED_TIMEOUT_EN
            run_cnt_q   <= run_cnt_d;
            tmo_q       <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_omp_col_sched.sv
// Bench for omp_col_sched: small batch (2 columns, 8/6/4 words) with a RAM_S and core model.
module tb_omp_col_sched;
    localparam int COL_NUM = 2;
    localparam int COL_W   = 1;
    localparam int QS      = 8;
    localparam int RS      = 6;
    localparam int SS      = 4;
    localparam int CD      = 8;
    localparam int AW      = 3;
    localparam int DW      = 16;
    localparam int TMO     = 16;
`ifdef OMP_SCHED_TIMEOUT_EN
    localparam int RUN_LAT = 10;
`else
    localparam int RUN_LAT = 20;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             batch_start = 1'b0;
    logic             omp_done = 1'b0;
    logic             out_ready = 1'b1;
    logic [DW-1:0]    s_q = '0;
    logic             batch_busy, batch_done, mem_sel, omp_start;
    logic [COL_W-1:0] col_idx;
    logic [AW-1:0]    clr_a, s_a;
    logic             clr_q_we, clr_r_we, clr_inv_r_we, clr_s_we, s_oe;
    logic             out_valid, out_last, timeout_err;
    logic [DW-1:0]    out_data;

    omp_col_sched #(
        .COL_NUM(COL_NUM), .COL_W(COL_W), .Q_MEM_SIZE(QS), .R_MEM_SIZE(RS),
        .S_MEM_SIZE(SS), .CLR_DEPTH(CD), .AW(AW), .DW(DW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .batch_start(batch_start), .batch_busy(batch_busy),
        .batch_done(batch_done), .col_idx(col_idx), .mem_sel(mem_sel),
        .omp_start(omp_start), .omp_done(omp_done), .clr_a(clr_a),
        .clr_q_we(clr_q_we), .clr_r_we(clr_r_we), .clr_inv_r_we(clr_inv_r_we),
        .clr_s_we(clr_s_we), .s_a(s_a), .s_oe(s_oe), .s_q(s_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int          vecs = 0;
    int          errs = 0;
    logic [16:0] exp_q [$];
    logic [16:0] exp_w;
    int          rx_words = 0;
    int          done_cnt = 0;
    int          n_start = 0;
    int          exp_col = 0;
    int          core_mode = 0;
    int          ready_mode = 0;
    bit          tmo_first = 0;
    logic [15:0] ram [0:7];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic raise_done();
        omp_done = 1'b1;
        for (int i = 0; i < SS; i++) exp_q.push_back({(i == SS - 1), 16'(17 * (i + 1))});
    endtask

    // RAM_S: registered read, data on s_q the cycle after s_oe
    always @(posedge clk) if (s_oe) s_q <= ram[s_a];

    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                    ph++;
                end
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                rx_words++;
                if (exp_q.size() == 0) chk("sb_extra_word", exp_q.size(), 1);
                else begin
                    exp_w = exp_q.pop_front();
                    chk("out_data", out_data, exp_w[15:0]);
                    chk("out_last", out_last, exp_w[16]);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (batch_done) done_cnt++;
            if (s_oe) chk("s_oe_mem_sel", mem_sel, 1);
        end
    end

    // OMP core model
    initial begin
        forever begin
            @(negedge clk);
            if (rst && omp_start) begin
                chk("start_col_idx", col_idx, exp_col);
                chk("start_mem_sel", mem_sel, 0);
                exp_col++;
                n_start++;
                if (core_mode == 0) begin
                    omp_done = 1'b0;
                    @(negedge clk);
                    chk("start_pulse_width", omp_start, 0);
                    repeat (RUN_LAT - 1) @(negedge clk);
                    raise_done();
                    @(negedge clk);
                    chk("first_s_oe", s_oe, 1);
                    chk("first_s_a", s_a, 0);
                    chk("drain_mem_sel", mem_sel, 1);
                    @(negedge clk);
                    chk("first_out_valid", out_valid, 1);
                    @(negedge clk);
                    omp_done = 1'b0;
                end else if (core_mode == 1) begin
                    if (omp_done) begin
                        for (int i = 0; i < 5; i++) begin
                            @(negedge clk);
                            chk("held_done_no_drain", s_oe, 0);
                            chk("held_done_run_sel", mem_sel, 0);
                            batch_start = (i == 1);
                        end
                        batch_start = 1'b0;
                        omp_done = 1'b0;
                        repeat (2) @(negedge clk);
                        raise_done();
                    end else begin
                        repeat (3) @(negedge clk);
                        raise_done();
                    end
                end
`ifdef OMP_SCHED_TIMEOUT_EN
                else if (tmo_first) begin
                    tmo_first = 0;
                    repeat (TMO) @(negedge clk);
                    chk("tmo_not_early", timeout_err, 0);
                    @(negedge clk);
                    chk("tmo_set", timeout_err, 1);
                end
`endif
            end
        end
    end

    task automatic start_batch();
        exp_col = 0;
        batch_start = 1'b1;
        @(negedge clk);
        batch_start = 1'b0;
    endtask

    task automatic wait_batch_done(input int maxc);
        bit   found = 0;
        logic busy_prev = 1'b1;
        for (int i = 0; i < maxc && !found; i++) begin
            @(negedge clk);
            if (batch_done) begin
                found = 1;
                chk("busy_falls_with_done", batch_busy, 0);
                chk("busy_before_done", busy_prev, 1);
            end
            busy_prev = batch_busy;
        end
        chk("batch_done_seen", found, 1);
        repeat (5) @(negedge clk);
        chk("idle_busy", batch_busy, 0);
    endtask

    task automatic run_checked(input string tag, input int exp_words);
        int rx0 = rx_words;
        int d0  = done_cnt;
        int s0  = n_start;
        start_batch();
        wait_batch_done(600);
        chk({tag, "_words"}, rx_words - rx0, exp_words);
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_starts"}, n_start - s0, COL_NUM);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int rx0, d0, s0;
        bit seen;
        for (int i = 0; i < 8; i++) ram[i] = (i < SS) ? 16'(17 * (i + 1)) : 16'h0;

        repeat (3) @(negedge clk);
        chk("rst_busy", batch_busy, 0);
        chk("rst_mem_sel", mem_sel, 1);
        chk("rst_col_idx", col_idx, 0);
        chk("rst_omp_start", omp_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_s_oe", s_oe, 0);
        chk("rst_clr_we", {clr_q_we, clr_r_we, clr_inv_r_we, clr_s_we}, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst = 1'b1;
        @(negedge clk);

        // clear sweep + normal batch
        core_mode = 0;
        ready_mode = 0;
        rx0 = rx_words; d0 = done_cnt; s0 = n_start;
        start_batch();
        for (int k = 0; k < CD; k++) begin
            chk("clr_a", clr_a, k);
            chk("clr_q_we", clr_q_we, (k < QS));
            chk("clr_r_we", clr_r_we, (k < RS));
            chk("clr_inv_r_we", clr_inv_r_we, (k < RS));
            chk("clr_s_we", clr_s_we, (k < SS));
            chk("clr_mem_sel", mem_sel, 1);
            chk("clr_no_start", omp_start, 0);
            @(negedge clk);
        end
        chk("start_after_clear", omp_start, 1);
        chk("start_clr_we_off", {clr_q_we, clr_r_we, clr_inv_r_we, clr_s_we}, 0);
        @(negedge clk);
        chk("start_one_cycle", omp_start, 0);
        wait_batch_done(600);
        chk("normal_words", rx_words - rx0, 2 * SS);
        chk("normal_done_pulses", done_cnt - d0, 1);
        chk("normal_starts", n_start - s0, COL_NUM);
        chk("normal_sb_empty", exp_q.size(), 0);

        // backpressure 1,0,0,1,...
        ready_mode = 1;
        run_checked("bp", 2 * SS);
        ready_mode = 0;

        // done level held across columns, batch_start during RUN
        core_mode = 1;
        run_checked("held_done", 2 * SS);

        // reset in the middle of a stalled drain
        core_mode = 0;
        ready_mode = 2;
        start_batch();
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("drain_reached", seen, 1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", batch_busy, 0);
        chk("mid_rst_mem_sel", mem_sel, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_s_oe", s_oe, 0);
        chk("mid_rst_col_idx", col_idx, 0);
        chk("mid_rst_out_data", out_data, 0);
        exp_q.delete();
        rst = 1'b1;
        ready_mode = 0;
        @(negedge clk);
        run_checked("after_rst", 2 * SS);

`ifdef OMP_SCHED_TIMEOUT_EN
        core_mode = 2;
        tmo_first = 1;
        chk("tmo_clear_before", timeout_err, 0);
        run_checked("tmo", 0);
        chk("tmo_sticky", timeout_err, 1);
`else
        chk("no_watchdog", timeout_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/omp_col_sched.md
# omp_col_sched

Column scheduler for the OMP reconstruction core. It runs a batch of COL_NUM compressed columns through a single OMP core. For each column it zero-clears RAM_Q, RAM_R, RAM_INV_R and RAM_S, pulses the core start, and waits for done. It then streams the RAM_S result words out on a valid/ready port. It sits between the system host and the OMP core plus RAM macros, and owns the RAM port mux select.

## Interface
- COL_NUM, 64: columns per batch.
- COL_W, 6: width of col_idx (≥ clog2(COL_NUM)).
- Q_MEM_SIZE, 256 / R_MEM_SIZE, 36 / S_MEM_SIZE, 256: words to clear per RAM.
- CLR_DEPTH, 256: clear sweep length; must equal the largest of the three sizes above.
- AW, 8: address width; 2^AW ≥ CLR_DEPTH.
- DW, 16: RAM_S data width.
- TIMEOUT_CYC, 1048576: watchdog limit (only with OMP_SCHED_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- batch_start  in  1  one-cycle request; honoured only in IDLE.
- batch_busy  out  1  high in every state except IDLE.
- batch_done  out  1  one-cycle pulse when the last column drains.
- col_idx  out  COL_W  current column; drives the ROM_Y column base.
- mem_sel  out  1  1 = scheduler owns RAM ports, 0 = OMP core owns them.
- omp_start  out  1  one-cycle start pulse to the core.
- omp_done  in  1  core done, level; only its rising edge is used.
- clr_a  out  AW  clear address, shared by all four RAMs (data is always 0).
- clr_q_we, clr_r_we, clr_inv_r_we, clr_s_we  out  1  per-RAM clear write enables.
- s_a  out  AW  RAM_S read address.
- s_oe  out  1  RAM_S read enable; data returns on s_q the next cycle.
- s_q  in  DW  RAM_S read data.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DW  result word.
- out_last  out  1  marks the last word of a column.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- States: IDLE, CLEAR, START, RUN, DRAIN, NEXT.
- IDLE:
  - batch_start=1 → col_idx←0, go to CLEAR.
  - batch_start is ignored in all other states.
- CLEAR:
  - mem_sel=1; clr_a counts 0..CLR_DEPTH-1, one address per cycle.
  - clr_x_we=1 only while clr_a < X_MEM_SIZE.
  - After CLR_DEPTH cycles → START.
- START:
  - mem_sel=0, omp_start=1 for exactly one cycle → RUN.
- RUN:
  - mem_sel=0; the scheduler registers omp_done.
  - On the first cycle where omp_done=1 and its registered value is 0 → DRAIN.
  - A done level already high on entry is not taken as an edge.
- DRAIN:
  - mem_sel=1; s_a counts 0..S_MEM_SIZE-1.
  - Output buffer is a 2-entry FIFO. A read is issued only when FIFO count plus in-flight reads is less than 2.
  - out_data, out_valid and out_last are driven from the FIFO head.
  - A word transfers when out_valid && out_ready.
  - out_last=1 on the word read from address S_MEM_SIZE-1.
  - After the last word transfers → NEXT.
- NEXT:
  - If col_idx == COL_NUM-1 → batch_done pulse, go to IDLE, col_idx holds its value.
  - Otherwise col_idx+1 → CLEAR.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_last hold stable. No word is dropped or duplicated.
- Reset mid-operation: everything returns to IDLE immediately and the FIFO is flushed. The OMP core and the RAMs are not touched.

## Timing
- Reset values:
  - All outputs 0 and col_idx=0.
  - mem_sel=1: RAMs are held idle under scheduler ownership.
- Latency from batch_start to the first clr write is 1 cycle.
- From CLEAR entry to omp_start is CLR_DEPTH cycles.
- omp_start is asserted on the cycle after the last clear write.
- From the omp_done rising edge to the first s_oe is 1 cycle. The first out_valid follows 1 cycle after that.
- Drain with out_ready held at 1: one word per cycle, S_MEM_SIZE+1 cycles from first s_oe to the out_last transfer.
- Per-column overhead with no stalls: CLR_DEPTH + 1 + 1 + S_MEM_SIZE + 2 cycles, plus the core run time.
- mem_sel changes only on state transitions, never inside a RAM access cycle.

## Configuration
- OMP_SCHED_TIMEOUT_EN defined:
  - A RUN cycle counter counts up from 0.
  - On reaching TIMEOUT_CYC without a done edge: timeout_err←1 (sticky until reset).
  - The column's drain is skipped (no output words) and the scheduler goes to NEXT.
- Macro undefined:
  - No counter is built and timeout_err is tied to 0.
  - RUN waits indefinitely for the done edge.

## Test plan
- Parameters for all scenarios: COL_NUM=2, Q/R/S sizes 8/6/4, CLR_DEPTH=8.
- Clear sweep: batch_start → 8 clear cycles. clr_q_we=1 for addresses 0-7, clr_r_we=1 for 0-5, clr_s_we=1 for 0-3. omp_start is a single pulse on cycle 9.
- Normal batch: model RAM_S holds 0x0011, 0x0022, 0x0033, 0x0044 and done rises 20 cycles after start, out_ready=1.
  - Required: 4 words per column in that order, out_last on 0x0044, col_idx goes 0 then 1.
  - batch_done pulses once and batch_busy falls the same cycle.
- Backpressure: out_ready toggled 1,0,0,1,… → the same 8 words with no loss or duplication, and data stays stable while stalled.
- Done handling: omp_done held high from the previous column into START/RUN → no DRAIN until done falls and rises again. batch_start pulsed during RUN → ignored.
- Reset: rst asserted low mid-DRAIN → next edge shows IDLE, all outputs 0, mem_sel=1. A new batch then restarts at col_idx=0.
- Timeout (macro on, TIMEOUT_CYC=16, done never rises):
  - timeout_err=1 after 16 RUN cycles, no words output, both columns processed, batch_done pulses.
